mlp_argmax: RTL and testbench

Post-processing stage directly downstream of the MLP core. After the core signals completion, this block scans the H signed 8-bit output-layer activations held in the data RAM output region (base 10'h200), finds the winning class (maximum value, lowest index on ties) and the margin to the runner-up. It presents {index, value, margin} on a valid/ready result port. It drives only the data RAM's second read port (registered read, 1-cycle latency) and never writes memory.

---
 rtl/mlp_argmax_if.sv | 27 ++
 rtl/mlp_argmax.sv | 153 +++++++++++++++
 tb/tb_mlp_argmax.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_argmax_if.sv
// Bundle of the argmax stage's control, RAM read-port and result-port signals.
// The "master" side is the argmax block itself; "slave" is whatever drives
// start/H, serves the data RAM read port and consumes results.
interface mlp_argmax_if #(
    parameter int AW = 10
);
    logic          start;
    logic [7:0]    H;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_idx;
    logic [7:0]    res_val;
    logic [8:0]    res_margin;

    modport master (
        input  start, H, rd_data, res_ready,
        output rd_addr, busy, res_valid, res_idx, res_val, res_margin
    );

    modport slave (
        output start, H, rd_data, res_ready,
        input  rd_addr, busy, res_valid, res_idx, res_val, res_margin
    );
endinterface

// File: rtl/mlp_argmax.sv
// Argmax post-processor for the MLP output layer. Streams H signed activations
// out of the data RAM output region, tracks the maximum (lowest index wins a
// tie) and the runner-up, then offers {index, value, margin} on a valid/ready
// result port. Reads only; never writes memory.
module mlp_argmax #(
    parameter int            AW   = 10,
    parameter logic [AW-1:0] BASE = 10'h200
) (
    input  logic         clk,
    input  logic         reset,
    mlp_argmax_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t               state_r;
    logic [7:0]           h_r;
    logic [7:0]           iss_cnt_r;
    logic                 issue_v_r;     // an address is being presented this cycle
    logic                 drain_wait_r;  // first DRAIN cycle: last compare still in flight
    logic [AW-1:0]        rd_addr_r;
    logic                 busy_r;
    logic                 res_valid_r;
    logic [7:0]           res_idx_r;
    logic [7:0]           res_val_r;
    logic [8:0]           res_margin_r;

    logic                 data_v_r;      // rd_data holds a requested element this cycle
    logic [7:0]           rcv_cnt_r;
    logic signed [7:0]    max_r;
    logic signed [7:0]    second_r;
    logic [7:0]           idx_r;

    logic                 start_acc_s;
    logic signed [7:0]    d_s;
    logic [8:0]           margin_s;

    assign start_acc_s = (state_r == IDLE) && bus.start;
    assign d_s         = bus.rd_data;
    // Sign-extended subtract; max is never below second, so the result is non-negative.
    assign margin_s    = {max_r[7], max_r} - {second_r[7], second_r};

    assign bus.rd_addr    = rd_addr_r;
    assign bus.busy       = busy_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_idx    = res_idx_r;
    assign bus.res_val    = res_val_r;
    assign bus.res_margin = res_margin_r;

    // Scan sequencer: address issue, drain of the read pipeline, result hand-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            h_r          <= 8'd0;
            iss_cnt_r    <= 8'd0;
            issue_v_r    <= 1'b0;
            drain_wait_r <= 1'b0;
            rd_addr_r    <= {AW{1'b0}};
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            res_idx_r    <= 8'd0;
            res_val_r    <= 8'd0;
            res_margin_r <= 9'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        h_r    <= bus.H;
                        busy_r <= 1'b1;
                        if (bus.H != 8'd0) begin
                            state_r   <= ISSUE;
                            rd_addr_r <= BASE;
                            iss_cnt_r <= 8'd1;
                            issue_v_r <= 1'b1;
                        end else begin
                            // Empty layer: fixed "no winner" result, valid one cycle later.
                            state_r      <= OUT;
                            res_idx_r    <= 8'hFF;
                            res_val_r    <= 8'h80;
                            res_margin_r <= 9'd0;
                        end
                    end
                end
                ISSUE: begin
                    if (iss_cnt_r < h_r) begin
                        rd_addr_r <= rd_addr_r + AW'(1);
                        iss_cnt_r <= iss_cnt_r + 8'd1;
                    end else begin
                        // Hold the last address; no further elements are requested.
                        issue_v_r    <= 1'b0;
                        drain_wait_r <= 1'b1;
                        state_r      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_wait_r) begin
                        drain_wait_r <= 1'b0;
                    end else begin
                        res_idx_r    <= idx_r;
                        res_val_r    <= max_r;
                        res_margin_r <= margin_s;
                        res_valid_r  <= 1'b1;
                        state_r      <= OUT;
                    end
                end
                OUT: begin
                    if (!res_valid_r) begin
                        res_valid_r <= 1'b1;
                    end else if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Compare unit: folds each returned element into the running max / runner-up.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_v_r  <= 1'b0;
            rcv_cnt_r <= 8'd0;
            max_r     <= 8'sd0;
            second_r  <= 8'sd0;
            idx_r     <= 8'd0;
        end else begin
            data_v_r <= issue_v_r;
            if (start_acc_s) begin
                rcv_cnt_r <= 8'd0;
            end else if (data_v_r) begin
                rcv_cnt_r <= rcv_cnt_r + 8'd1;
                if (rcv_cnt_r == 8'd0) begin
                    max_r    <= d_s;
                    idx_r    <= 8'd0;
                    second_r <= -8'sd128;
                end else if (d_s > max_r) begin
                    second_r <= max_r;
                    max_r    <= d_s;
                    idx_r    <= rcv_cnt_r;
                end else if (d_s > second_r) begin
                    second_r <= d_s;
                end else begin
                    second_r <= second_r;
                end
            end else begin
                rcv_cnt_r <= rcv_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_mlp_argmax.sv
// Self-checking bench for mlp_argmax: directed vectors with hand-computed
// results, back-pressure, mid-scan reset and a randomized sweep against a
// small behavioural reference.
module tb_mlp_argmax;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] mem [0:1023];

    mlp_argmax_if bus ();

    mlp_argmax #(.AW(10), .BASE(10'h200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data RAM second read port: registered read, one-cycle latency.
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    // Start a scan, wait for the result, capture it and complete the handshake
    // with res_ready high. lat = edges from start edge to res_valid (-1 on timeout).
    task automatic run_scan(input logic [7:0] h, output int lat, output logic [7:0] idx,
                            output logic [7:0] val, output logic [8:0] mg,
                            output int addr_err, output logic post_idle);
        logic [9:0] exp_a;
        @(negedge clk);
        bus.H = h; bus.start = 1'b1; bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        addr_err = 0; lat = -1;
        if (h != 8'd0 && bus.rd_addr !== 10'h200) addr_err++;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            exp_a = 10'h200 + 10'(c);
            if (c < int'(h) && bus.rd_addr !== exp_a) addr_err++;
            if (bus.res_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        idx = bus.res_idx; val = bus.res_val; mg = bus.res_margin;
        @(posedge clk); #1;
        post_idle = (bus.res_valid === 1'b0) && (bus.busy === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rd_addr !== 10'h000) begin
            failures++;
            $display("FAIL reset_state valid=%b busy=%b rd_addr=%h exp 0/0/000", bus.res_valid, bus.busy, bus.rd_addr);
        end
        checks++;
        if (bus.res_idx !== 8'h00 || bus.res_val !== 8'h00 || bus.res_margin !== 9'h000) begin
            failures++;
            $display("FAIL reset_result idx=%h val=%h mg=%h exp 00/00/000", bus.res_idx, bus.res_val, bus.res_margin);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_tie();
        int lat, ae; logic [7:0] idx, val; logic [8:0] mg; logic pi;
        mem[10'h200] = 8'd5;   mem[10'h201] = 8'hFD; mem[10'h202] = 8'd90;
        mem[10'h203] = 8'd12;  mem[10'h204] = 8'd90; mem[10'h205] = 8'h9C;
        run_scan(8'd6, lat, idx, val, mg, ae, pi);
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL tie_latency got=%0d exp=8", lat); end
        checks++;
        if (idx !== 8'd2 || val !== 8'd90 || mg !== 9'd0) begin
            failures++; $display("FAIL tie_result idx=%0d val=%0d mg=%0d exp 2/90/0", idx, val, mg);
        end
        checks++;
        if (ae !== 0) begin failures++; $display("FAIL tie_addr_seq errors=%0d exp=0", ae); end
        checks++;
        if (pi !== 1'b1) begin failures++; $display("FAIL tie_handshake_idle got=%b exp=1", pi); end
    endtask

    task automatic test_negative();
        int lat, ae; logic [7:0] idx, val; logic [8:0] mg; logic pi;
        mem[10'h200] = 8'hF9; mem[10'h201] = 8'hEC; mem[10'h202] = 8'h80;
        run_scan(8'd3, lat, idx, val, mg, ae, pi);
        checks++;
        if (lat !== 5 || idx !== 8'd0 || val !== 8'hF9 || mg !== 9'd13) begin
            failures++;
            $display("FAIL negative lat=%0d idx=%0d val=%h mg=%0d exp 5/0/f9/13", lat, idx, val, mg);
        end
    endtask

    task automatic test_single_and_zero();
        int lat, ae; logic [7:0] idx, val; logic [8:0] mg; logic pi;
        mem[10'h200] = 8'h80;
        run_scan(8'd1, lat, idx, val, mg, ae, pi);
        checks++;
        if (lat !== 3 || idx !== 8'd0 || val !== 8'h80 || mg !== 9'd0) begin
            failures++;
            $display("FAIL single lat=%0d idx=%0d val=%h mg=%0d exp 3/0/80/0", lat, idx, val, mg);
        end
        run_scan(8'd0, lat, idx, val, mg, ae, pi);
        checks++;
        if (lat !== 1 || idx !== 8'hFF || val !== 8'h80 || mg !== 9'd0) begin
            failures++;
            $display("FAIL zero_h lat=%0d idx=%h val=%h mg=%0d exp 1/ff/80/0", lat, idx, val, mg);
        end
        checks++;
        if (pi !== 1'b1) begin failures++; $display("FAIL zero_h_idle got=%b exp=1", pi); end
    endtask

    task automatic test_backpressure();
        int unstable = 0, extra = 0, lat = -1;
        mem[10'h200] = 8'd10; mem[10'h201] = 8'd30; mem[10'h202] = 8'd20;
        @(negedge clk);
        bus.H = 8'd3; bus.start = 1'b1; bus.res_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (bus.res_valid === 1'b1) begin lat = c; break; end
        end
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL bp_latency got=%0d exp=5", lat); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.start = (c == 3); bus.H = 8'd2;
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b1 || bus.res_idx !== 8'd1 || bus.res_val !== 8'd30 ||
                bus.res_margin !== 9'd10 || bus.busy !== 1'b1) unstable++;
        end
        checks++;
        if (unstable !== 0) begin failures++; $display("FAIL bp_stable unstable_cycles=%0d exp=0", unstable); end
        @(negedge clk);
        bus.start = 1'b0; bus.res_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.res_valid === 1'b1 || bus.busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL bp_single_result extra_cycles=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid_scan();
        int lat, ae, leaked = 0; logic [7:0] idx, val; logic [8:0] mg; logic pi;
        for (int i = 0; i < 26; i++) mem[10'h200 + i] = 8'(i);
        mem[10'h200 + 20] = 8'd100;
        @(negedge clk);
        bus.H = 8'd26; bus.start = 1'b1; bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rd_addr !== 10'h000) begin
            failures++;
            $display("FAIL midscan_reset valid=%b busy=%b rd_addr=%h exp 0/0/000", bus.res_valid, bus.busy, bus.rd_addr);
        end
        reset = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            if (bus.res_valid === 1'b1 || bus.busy === 1'b1) leaked++;
        end
        checks++;
        if (leaked !== 0) begin failures++; $display("FAIL midscan_no_partial cycles=%0d exp=0", leaked); end
        run_scan(8'd26, lat, idx, val, mg, ae, pi);
        checks++;
        if (lat !== 28 || idx !== 8'd20 || val !== 8'd100 || mg !== 9'd75 || ae !== 0) begin
            failures++;
            $display("FAIL midscan_rescan lat=%0d idx=%0d val=%0d mg=%0d addr_err=%0d exp 28/20/100/75/0",
                     lat, idx, val, mg, ae);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, ae1, ae2; logic [7:0] i1, v1, i2, v2; logic [8:0] m1, m2; logic p1, p2;
        mem[10'h200] = 8'hF0; mem[10'h201] = 8'hF5; mem[10'h202] = 8'h7F; mem[10'h203] = 8'h00;
        run_scan(8'd2, lat1, i1, v1, m1, ae1, p1);
        run_scan(8'd4, lat2, i2, v2, m2, ae2, p2);
        checks++;
        if (lat1 !== 4 || i1 !== 8'd1 || v1 !== 8'hF5 || m1 !== 9'd5) begin
            failures++; $display("FAIL b2b_first lat=%0d idx=%0d val=%h mg=%0d exp 4/1/f5/5", lat1, i1, v1, m1);
        end
        checks++;
        if (lat2 !== 6 || i2 !== 8'd2 || v2 !== 8'h7F || m2 !== 9'd127) begin
            failures++; $display("FAIL b2b_second lat=%0d idx=%0d val=%h mg=%0d exp 6/2/7f/127", lat2, i2, v2, m2);
        end
    endtask

    task automatic test_random();
        int lat, ae, h, mx, sc, mi, v; logic [7:0] idx, val; logic [8:0] mg; logic pi;
        int bad = 0;
        for (int n = 0; n < 1000; n++) begin
            h = $urandom_range(1, 26);
            for (int i = 0; i < h; i++) begin
                if (n % 3 == 0) mem[10'h200 + i] = 8'($urandom_range(0, 3) + 124);
                else            mem[10'h200 + i] = 8'($urandom_range(0, 255));
            end
            mx = -1000; sc = -128; mi = 0;
            for (int i = 0; i < h; i++) begin
                v = int'($signed(mem[10'h200 + i]));
                if (i == 0) begin mx = v; mi = 0; sc = -128; end
                else if (v > mx) begin sc = mx; mx = v; mi = i; end
                else if (v > sc) sc = v;
            end
            run_scan(8'(h), lat, idx, val, mg, ae, pi);
            checks++;
            if (lat !== h + 2 || idx !== 8'(mi) || val !== 8'(mx) || mg !== 9'(mx - sc) || ae !== 0 || pi !== 1'b1) begin
                failures++; bad++;
                if (bad <= 10)
                    $display("FAIL random_scan n=%0d h=%0d lat=%0d idx=%0d val=%0d mg=%0d exp %0d/%0d/%0d/%0d",
                             n, h, lat, idx, $signed(val), mg, h + 2, mi, mx, mx - sc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        bus.start = 1'b0; bus.H = 8'd0; bus.res_ready = 1'b0;
        test_reset();
        test_tie();
        test_negative();
        test_single_and_zero();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
